ma_interpolator: RTL and testbench

//  Interpolating (upsampling) counterpart of the moving-average decimation path. Accepts one
//  low-rate sample per valid/ready handshake and emits 2**INTERP_LOG2 output samples that

---
 rtl/ma_interp_pkg.sv | 25 ++
 rtl/ma_interpolator.sv | 116 +++++++++++
 tb/tb_ma_interpolator.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ma_interp_pkg.sv
// Shared types and width helpers for the moving-average interpolator.
// Optional rounding is selected in ma_interpolator with MA_INTERP_ROUND_EN.
package ma_interp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ma_interp_state_e;

    localparam int unsigned DATA_WIDTH_DEFAULT  = 16;
    localparam int unsigned INTERP_LOG2_DEFAULT = 3;

    // Accumulator holds x_prev*R plus a signed delta, so it needs one sign bit on top.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned il2);
        return dw + il2 + 1;
    endfunction

    function automatic int unsigned delta_width(input int unsigned dw);
        return dw + 1;
    endfunction

    localparam int unsigned ACC_WIDTH_DEFAULT   = acc_width(DATA_WIDTH_DEFAULT, INTERP_LOG2_DEFAULT);
    localparam int unsigned DELTA_WIDTH_DEFAULT = delta_width(DATA_WIDTH_DEFAULT);

endpackage

// File: rtl/ma_interpolator.sv
// Linear-ramp interpolator: one input sample per handshake, 2**INTERP_LOG2 output samples.
// Define MA_INTERP_ROUND_EN for round-half-up output scaling instead of truncation.
module ma_interpolator
    import ma_interp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int unsigned INTERP_LOG2 = INTERP_LOG2_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int unsigned ACC_W   = acc_width(DATA_WIDTH, INTERP_LOG2);
    localparam int unsigned DELTA_W = delta_width(DATA_WIDTH);
    localparam logic [INTERP_LOG2-1:0] LAST_PHASE = '1;

`ifdef MA_INTERP_ROUND_EN
    localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) <<< (INTERP_LOG2 - 1);
`endif

    ma_interp_state_e        state_q,     state_d;
    logic [DATA_WIDTH-1:0]   x_prev_q,    x_prev_d;
    logic [INTERP_LOG2-1:0]  phase_q,     phase_d;
    logic signed [ACC_W-1:0] acc_q,       acc_d;
    logic signed [DELTA_W-1:0] delta_q,   delta_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;

    logic                      last_phase;
    logic                      out_fire;
    logic                      accept;
    logic signed [DELTA_W-1:0] delta_new;
    logic signed [ACC_W-1:0]   acc_new;
    logic signed [ACC_W-1:0]   acc_step;

    function automatic logic [DATA_WIDTH-1:0] scale(input logic signed [ACC_W-1:0] a);
`ifdef MA_INTERP_ROUND_EN
        return DATA_WIDTH'((a + ROUND_HALF) >>> INTERP_LOG2);
`else
        return DATA_WIDTH'(a >>> INTERP_LOG2);
`endif
    endfunction

    assign last_phase = (phase_q == LAST_PHASE);
    assign out_fire   = out_valid_q && out_ready;

    // Ready on the final-phase handshake lets the next ramp start without a bubble.
    assign in_ready = reset_n && ((state_q == IDLE) || (last_phase && out_fire));
    assign accept   = in_valid && in_ready;

    assign delta_new = $signed({1'b0, in_data}) - $signed({1'b0, x_prev_q});
    assign acc_new   = $signed({1'b0, x_prev_q, {INTERP_LOG2{1'b0}}})
                     + $signed({{INTERP_LOG2{delta_new[DELTA_W-1]}}, delta_new});
    assign acc_step  = acc_q + $signed({{INTERP_LOG2{delta_q[DELTA_W-1]}}, delta_q});

    // NOTE: every next-state signal gets a hold default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        x_prev_d    = x_prev_q;
        phase_d     = phase_q;
        acc_d       = acc_q;
        delta_d     = delta_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (accept) begin
            state_d     = RUN;
            x_prev_d    = in_data;
            delta_d     = delta_new;
            acc_d       = acc_new;
            phase_d     = '0;
            out_valid_d = 1'b1;
            out_data_d  = scale(acc_new);
        end else if (out_fire) begin
            if (!last_phase) begin
                phase_d    = phase_q + INTERP_LOG2'(1);
                acc_d      = acc_step;
                out_data_d = scale(acc_step);
            end else begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_prev_q    <= '0;
            phase_q     <= '0;
            acc_q       <= '0;
            delta_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_prev_q    <= x_prev_d;
            phase_q     <= phase_d;
            acc_q       <= acc_d;
            delta_q     <= delta_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_ma_interpolator.sv
// Scoreboard bench for ma_interpolator (R=8, 16-bit); honours MA_INTERP_ROUND_EN.
module tb_ma_interpolator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int compared   = 0;
    int mismatched = 0;
    int exp_q[$];
    int model_prev = 0;
    int cyc        = 0;
    int rdy_cnt    = 0;
    int beat_cnt   = 0;
    int first_cyc  = 0;
    int last_cyc   = 0;

    ma_interpolator #(.DATA_WIDTH(16), .INTERP_LOG2(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        compared++;
        mismatched++;
        $error("FAIL %s: observed no event, expected event", tag);
    endtask

    // Expected ramp: floor((prev*8 + (new-prev)*(k+1) [+4]) / 8) for k = 0..7.
    task automatic push_ramp(input int prev, input int nxt);
        for (int k = 0; k < 8; k++) begin
            int a;
            a = prev * 8 + (nxt - prev) * (k + 1);
`ifdef MA_INTERP_ROUND_EN
            a = a + 4;
`endif
            exp_q.push_back(a / 8);
        end
    endtask

    task automatic send(input int x, input bit use_model, input bit keep_valid);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = x[15:0];
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                if (use_model) push_ramp(model_prev, x);
                model_prev = x;
                done       = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!keep_valid) in_valid = 1'b0;
        if (!done) fail_now("accept_timeout");
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && out_valid === 1'b0) done = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!done) fail_now("drain_timeout");
    endtask

    always @(negedge clk) begin
        cyc++;
        if (in_ready === 1'b1) rdy_cnt++;
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (beat_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            beat_cnt++;
            if (exp_q.size() == 0) fail_now("unexpected_output");
            else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        reset_n = 1'b1;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Ramp up from reset value 0, first output one cycle after accept.
        send(800, 1'b1, 1'b0);
        check("latency_valid", 32'(out_valid), 32'd1);
        check("latency_data",  32'(out_data),  32'd100);
        drain();

        // Ramp back down, then return to idle.
        send(0, 1'b1, 1'b0);
        drain();
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready2", 32'(in_ready),  32'd1);

        // Backpressure while phase 2 (300) is presented.
        send(800, 1'b1, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_data",  32'(out_data),  32'd300);
            check("stall_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // Back-to-back ramps with in_valid held high.
        rdy_cnt  = 0;
        beat_cnt = 0;
        send(800, 1'b1, 1'b1);
        send(0,   1'b1, 1'b1);
        send(800, 1'b1, 1'b0);
        check("stream_ready_pulses", 32'(rdy_cnt), 32'd3);
        drain();
        check("stream_beats", 32'(beat_cnt), 32'd24);
        check("stream_span",  32'(last_cyc - first_cyc), 32'd23);

        // Reset in the middle of a ramp abandons it.
        send(0, 1'b1, 1'b0);
        drain();
        send(800, 1'b1, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_data", 32'(out_data), 32'd500);
        reset_n = 1'b0;
        exp_q.delete();
        model_prev = 0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        reset_n = 1'b1;
        send(80, 1'b1, 1'b0);
        drain();

        // Small step exercising the truncation/rounding table.
        send(0, 1'b1, 1'b0);
        drain();
`ifdef MA_INTERP_ROUND_EN
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q = '{0, 1, 1, 2, 2, 2, 3, 3};
`else
        exp_q = '{0, 0, 1, 1, 1, 2, 2, 3};
`endif
        send(3, 1'b0, 1'b0);
        drain();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
